// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right, shift left and parallel load, with a registered
// serial output and a shift counter that pulses word_valid when a WIDTH-bit serial word completes.
module univ_shift_reg #(
    parameter int unsigned WIDTH = 4,
    localparam int unsigned CW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [1:0]       mode,
    input  logic             in,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] d,
    output logic             sout,
    output logic [CW-1:0]    cnt,
    output logic             word_valid
);

    typedef enum logic [1:0] {
        ModeHold = 2'b00,
        ModeShr  = 2'b01,
        ModeShl  = 2'b10,
        ModeLoad = 2'b11
    } mode_e;

    localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("univ_shift_reg: WIDTH must be in 2..32");
    end

    logic [WIDTH-1:0] d_q, d_d;
    logic             sout_q, sout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             word_valid_q, word_valid_d;
    logic             shift;

    always_comb begin
        d_d          = d_q;
        sout_d       = sout_q;
        cnt_d        = cnt_q;
        word_valid_d = 1'b0;
        shift        = 1'b0;

        if (clr) begin
            d_d    = '0;
            sout_d = 1'b0;
            cnt_d  = '0;
        end else begin
            unique case (mode_e'(mode))
                ModeHold: ;
                ModeShr: begin
                    d_d    = {in, d_q[WIDTH-1:1]};
                    sout_d = d_q[0];
                    shift  = 1'b1;
                end
                ModeShl: begin
                    d_d    = {d_q[WIDTH-2:0], in};
                    sout_d = d_q[WIDTH-1];
                    shift  = 1'b1;
                end
                ModeLoad: begin
                    d_d   = pin;
                    cnt_d = '0;
                end
                default: ;
            endcase

            // Direction is irrelevant to word framing; any shift advances the count.
            if (shift) begin
                if (cnt_q == CntLast) begin
                    cnt_d        = '0;
                    word_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_q          <= '0;
            sout_q       <= 1'b0;
            cnt_q        <= '0;
            word_valid_q <= 1'b0;
        end else begin
            d_q          <= d_d;
            sout_q       <= sout_d;
            cnt_q        <= cnt_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign d          = d_q;
    assign sout       = sout_q;
    assign cnt        = cnt_q;
    assign word_valid = word_valid_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: WIDTH=4 and WIDTH=8 instances share stimulus and are checked each
// cycle against an arithmetic model, plus literal expectations for the directed scenarios.
module tb_univ_shift_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       sin;
    logic [1:0] mode;
    logic [7:0] pin8;

    logic [3:0] d4;
    logic       sout4;
    logic [1:0] cnt4;
    logic       wv4;
    logic [7:0] d8;
    logic       sout8;
    logic [2:0] cnt8;
    logic       wv8;

    int  n_tests = 0;
    int  n_fail  = 0;
    bit  chk_en  = 1'b0;

    // Model state per instance: index 0 is WIDTH=4, index 1 is WIDTH=8.
    int unsigned md[2];
    int unsigned ms[2];
    int unsigned mc[2];
    int unsigned mw[2];

    int unsigned exp_d1[4]  = '{1, 2, 5, 11};
    int unsigned exp_d2[4]  = '{8, 4, 10, 13};
    int unsigned exp_s3[4]  = '{1, 0, 1, 0};
    int unsigned exp_c4[11] = '{1, 2, 2, 2, 2, 3, 0, 1, 2, 3, 0};
    int unsigned exp_w4[11] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1};
    logic [3:0]  bits1      = 4'b1011;
    logic [7:0]  a5         = 8'hA5;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .clr(clr), .mode(mode), .in(sin), .pin(pin8[3:0]),
        .d(d4), .sout(sout4), .cnt(cnt4), .word_valid(wv4)
    );

    univ_shift_reg #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .clr(clr), .mode(mode), .in(sin), .pin(pin8),
        .d(d8), .sout(sout8), .cnt(cnt8), .word_valid(wv8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_zero();
        for (int k = 0; k < 2; k++) begin
            md[k] = 0; ms[k] = 0; mc[k] = 0; mw[k] = 0;
        end
    endtask

    // Applied at each rising edge with the inputs the DUTs sampled.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int unsigned w;
            int unsigned mask;
            w    = (k == 0) ? 4 : 8;
            mask = (1 << w) - 1;
            if (!rst || clr) begin
                md[k] = 0; ms[k] = 0; mc[k] = 0; mw[k] = 0;
            end else if (mode == 2'd0) begin
                mw[k] = 0;
            end else if (mode == 2'd3) begin
                md[k] = int'(pin8) & mask;
                mc[k] = 0;
                mw[k] = 0;
            end else begin
                if (mode == 2'd1) begin
                    ms[k] = md[k] & 1;
                    md[k] = (md[k] >> 1) | (int'(sin) << (w - 1));
                end else begin
                    ms[k] = (md[k] >> (w - 1)) & 1;
                    md[k] = ((md[k] << 1) | int'(sin)) & mask;
                end
                mc[k] = mc[k] + 1;
                if (mc[k] == w) begin
                    mc[k] = 0;
                    mw[k] = 1;
                end else begin
                    mw[k] = 0;
                end
            end
        end
    endtask

    // Called just after a falling edge; returns at the next falling edge.
    task automatic tick(input logic [1:0] m, input logic i, input logic [7:0] p, input logic c);
        mode = m; sin = i; pin8 = p; clr = c;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_d4"}, d4, 0);     chk({tag, "_cnt4"}, cnt4, 0);
        chk({tag, "_sout4"}, sout4, 0); chk({tag, "_wv4"}, wv4, 0);
        chk({tag, "_d8"}, d8, 0);     chk({tag, "_cnt8"}, cnt8, 0);
        chk({tag, "_sout8"}, sout8, 0); chk({tag, "_wv8"}, wv8, 0);
    endtask

    // Asynchronous reset between edges, held across one rising edge.
    task automatic async_reset();
        mode = 2'd0; clr = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        model_zero();
        check_all_zero("async_rst");
        @(posedge clk);
        model_step();
        @(negedge clk);
        rst = 1'b1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_d4", d4, md[0]);     chk("cyc_sout4", sout4, ms[0]);
            chk("cyc_cnt4", cnt4, mc[0]); chk("cyc_wv4", wv4, mw[0]);
            chk("cyc_d8", d8, md[1]);     chk("cyc_sout8", sout8, ms[1]);
            chk("cyc_cnt8", cnt8, mc[1]); chk("cyc_wv8", wv8, mw[1]);
        end
    end

    initial begin
        rst = 1'b0; clr = 1'b0; mode = 2'd0; sin = 1'b0; pin8 = 8'h00;
        model_zero();
        #1;
        check_all_zero("por");
        @(negedge clk);
        check_all_zero("rst_held");
        rst = 1'b1;
        chk_en = 1'b1;

        // Deserialise MSB-first with shift left.
        for (int i = 0; i < 4; i++) begin
            tick(2'd2, bits1[3-i], 8'h00, 1'b0);
            chk("deser_d", d4, exp_d1[i]);
            chk("deser_cnt", cnt4, (i + 1) % 4);
            chk("deser_wv", wv4, (i == 3) ? 1 : 0);
        end
        chk("deser_d8", d8, 8'h0B);
        chk("deser_cnt8", cnt8, 4);

        // Shift right after reset.
        async_reset();
        for (int i = 0; i < 4; i++) begin
            tick(2'd1, bits1[3-i], 8'h00, 1'b0);
            chk("shr_d", d4, exp_d2[i]);
            chk("shr_sout", sout4, 0);
            chk("shr_wv", wv4, (i == 3) ? 1 : 0);
        end

        // Parallel load then serialise out of sout.
        tick(2'd3, 1'b1, 8'h5A, 1'b0);
        chk("load_d", d4, 4'hA);
        chk("load_cnt", cnt4, 0);
        chk("load_wv", wv4, 0);
        chk("load_sout", sout4, 0);
        chk("load_d8", d8, 8'h5A);
        for (int i = 0; i < 4; i++) begin
            tick(2'd2, 1'b0, 8'hFF, 1'b0);
            chk("p2s_sout", sout4, exp_s3[i]);
            chk("p2s_wv", wv4, (i == 3) ? 1 : 0);
        end
        chk("p2s_final_d", d4, 0);

        // Hold inside a word, then a continuous stream with mixed directions.
        for (int i = 0; i < 11; i++) begin
            logic [1:0] m;
            if (i >= 2 && i <= 4) m = 2'd0;
            else m = ($urandom_range(0, 1) == 0) ? 2'd1 : 2'd2;
            tick(m, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b0);
            chk("stream_cnt", cnt4, exp_c4[i]);
            chk("stream_wv", wv4, exp_w4[i]);
        end

        // Reset mid-word discards the partial word.
        tick(2'd3, 1'b0, 8'hFF, 1'b0);
        for (int i = 0; i < 3; i++) tick(2'd2, 1'b1, 8'h00, 1'b0);
        chk("pre_rst_cnt", cnt4, 3);
        chk("pre_rst_sout", sout4, 1);
        async_reset();
        tick(2'd0, 1'b0, 8'h00, 1'b0);
        chk("post_rst_wv", wv4, 0);

        // clr beats a simultaneous load.
        tick(2'd3, 1'b0, 8'hFF, 1'b0);
        for (int i = 0; i < 3; i++) tick(2'd2, 1'b1, 8'h00, 1'b0);
        tick(2'd3, 1'b1, 8'hFF, 1'b1);
        chk("clr_d", d4, 0);
        chk("clr_cnt", cnt4, 0);
        chk("clr_sout", sout4, 0);
        chk("clr_wv", wv4, 0);
        chk("clr_d8", d8, 0);

        // Load on what would have been the terminal shift suppresses the pulse.
        for (int i = 0; i < 3; i++) tick(2'd1, 1'b1, 8'h00, 1'b0);
        tick(2'd3, 1'b0, 8'h06, 1'b0);
        chk("term_load_d", d4, 6);
        chk("term_load_cnt", cnt4, 0);
        chk("term_load_wv", wv4, 0);

        // WIDTH=8: 8'hA5 MSB-first.
        async_reset();
        for (int i = 0; i < 8; i++) begin
            tick(2'd2, a5[7-i], 8'h00, 1'b0);
            chk("w8_cnt", cnt8, (i + 1) % 8);
            chk("w8_wv", wv8, (i == 7) ? 1 : 0);
        end
        chk("w8_d", d8, 8'hA5);
        tick(2'd2, 1'b0, 8'h00, 1'b0);
        chk("w8_next_cnt", cnt8, 1);
        chk("w8_next_wv", wv8, 0);

        // Randomised traffic checked by the per-cycle compare.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                async_reset();
            end else begin
                tick(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     8'($urandom_range(0, 255)), $urandom_range(0, 19) == 0);
            end
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register that succeeds the fixed 4-bit serial-in/parallel-out register. It supports hold, shift-left, shift-right and parallel-load modes, and provides a registered serial output. A shift counter flags each completed WIDTH-bit serial word, so downstream logic can capture deserialised data without its own bit counter.

## Interface
- WIDTH, default 4: register width in bits; legal range 2..32.
- CW, default $clog2(WIDTH): shift-counter width. This is a derived localparam and must not be overridden.

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- clr  in  1  synchronous clear; highest priority after rst
- mode  in  2  00 hold, 01 shift right, 10 shift left, 11 parallel load
- in  in  1  serial data in
- pin  in  WIDTH  parallel load data
- d  out  WIDTH  register contents
- sout  out  1  registered bit shifted out on the last shift
- cnt  out  CW  shifts completed in the current word, 0..WIDTH-1
- word_valid  out  1  one-cycle pulse: d holds a complete WIDTH-bit serial word

## Operation
- Priority per rising edge: rst (asynchronous) > clr > mode.
- rst low: d=0, sout=0, cnt=0, word_valid=0 immediately. Outputs stay there while rst is low. Release is synchronous to clk in the system; the block needs no internal synchroniser.
- clr=1: d, sout, cnt and word_valid all go to 0 on the next edge.
- mode 00 (hold): d, sout and cnt are unchanged; word_valid=0.
- mode 10 (shift left): d <= {d[WIDTH-2:0], in}; sout <= d[WIDTH-1].
- mode 01 (shift right): d <= {in, d[WIDTH-1:1]}; sout <= d[0].
- mode 11 (load): d <= pin; sout unchanged; cnt <= 0; word_valid=0.
- Counter behaviour on any shift (01 or 10):
  - if cnt==WIDTH-1: cnt <= 0 and word_valid <= 1;
  - otherwise: cnt <= cnt+1 and word_valid <= 0.
- The counter counts shifts regardless of direction. Changing direction mid-word does not restart the word.
- Hold cycles inside a word are allowed. They pause cnt, and the word completes on the WIDTH-th shift.
- Back-to-back words: shifting continuously gives a word_valid pulse every WIDTH cycles, with no dead cycle.
- No arithmetic beyond the CW-bit counter. The counter never reaches WIDTH; it wraps to 0 on the terminal shift.

## Timing
- All outputs are registered. Latency from the input-sampling edge to the output change is 1 clock.
- word_valid is high for exactly the cycle that follows the WIDTH-th shift. In that cycle d holds the complete word and cnt=0.
- The first word after reset, clr or load completes on the WIDTH-th shift edge. Its word_valid is visible one cycle after that edge.
- A shift on the cycle immediately after a word_valid pulse is legal and starts the next word (cnt becomes 1).
- Reset asserted mid-word discards the partial word. No word_valid is produced for it.
- clr and mode=11 on the same edge: clr wins, so d=0, not pin.
- mode=11 on the edge that would have been terminal: the load wins, cnt=0 and there is no word_valid pulse.
- in and pin are sampled only on the edge; they have no effect in other modes.

## Test plan
- Reset/deserialise (WIDTH=4): rst=0 for 1 cycle, then mode=10 with in=1,0,1,1. Required: d=0001, 0010, 0101, 1011; cnt=1, 2, 3, 0; word_valid=1 only in the cycle where d=1011.
- Shift right (WIDTH=4): after reset, mode=01 with in=1,0,1,1. Required: d=1000, 0100, 1010, 1101; word_valid pulses with d=1101; sout=0, 0, 0, 0.
- Parallel-to-serial: mode=11 with pin=1010, then mode=10 with in=0 for 4 cycles. Required: sout=1, 0, 1, 0; final d=0000; word_valid pulses after the 4th shift.
- Hold and continuous stream: shift 2 bits, hold for 3 cycles, shift 2 more bits, then shift 4 more bits. Required: cnt frozen at 2 during the hold; word_valid after the 4th shift and again exactly 4 cycles later.
- Mid-word interrupts: after 3 shifts, assert rst asynchronously between edges. Required: d, cnt and sout are 0 immediately, with no word_valid. Repeat using clr=1 together with mode=11 and pin=1111. Required: d=0000.
- WIDTH=8 instance: shift 8'hA5 MSB-first with mode=10. Required: d=8'hA5 and word_valid on the 8th shift; cnt walks 1..7 then returns to 0.
